// File: rtl/vga_sync_gen_param.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen_param
// Purpose  : Parametrised VGA timing generator. A clock divider produces the
//            pixel-rate enable p_tick. The raster counters pix_X and pix_Y
//            free-run over H_TOTAL x V_TOTAL positions. The block also
//            produces registered sync, visible-area, line and frame strobes
//            and a frame-locked blink signal used to flash fields under edit.
// Ports    : CLK_TB      in   system clock
//            RESET_TB    in   synchronous reset, active low
//            p_tick      out  pixel enable, one CLK_TB cycle every CLK_DIV
//            h_sync      out  horizontal sync (active level = SYNC_POL)
//            v_sync      out  vertical sync   (active level = SYNC_POL)
//            videon      out  pix_X/pix_Y lies inside the visible area
//            pix_X       out  current column, 0..H_TOTAL-1
//            pix_Y       out  current row,    0..V_TOTAL-1
//            line_end    out  one-cycle pulse after the tick that wraps pix_X
//            frame_start out  one-cycle pulse after the tick that wraps to (0,0)
//            blink       out  toggles every BLINK_FRAMES frames
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen_param #(
    parameter  int H_DISPLAY    = 640,
    parameter  int H_FRONT      = 16,
    parameter  int H_SYNC       = 96,
    parameter  int H_BACK       = 48,
    parameter  int V_DISPLAY    = 480,
    parameter  int V_FRONT      = 10,
    parameter  int V_SYNC       = 2,
    parameter  int V_BACK       = 33,
    parameter  int CLK_DIV      = 4,
    parameter  int SYNC_POL     = 0,
    parameter  int BLINK_FRAMES = 30,
    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int XW           = $clog2(H_TOTAL),
    localparam int YW           = $clog2(V_TOTAL)
) (
    input  logic          CLK_TB,
    input  logic          RESET_TB,
    output logic          p_tick,
    output logic          h_sync,
    output logic          v_sync,
    output logic          videon,
    output logic [XW-1:0] pix_X,
    output logic [YW-1:0] pix_Y,
    output logic          line_end,
    output logic          frame_start,
    output logic          blink
);

    // Counter widths are kept at least one bit so CLK_DIV=1 and
    // BLINK_FRAMES=1 still yield legal vectors.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);

    // Sync windows, end bound exclusive.
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_next;
    logic [FW-1:0] frame_cnt;

    logic          x_last;
    logic          y_last;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    logic          h_act_next;
    logic          v_act_next;
    logic          vid_next;

    // Next-position decode. The sync and visible flags are registered from
    // this decode on the advancing edge, so they always line up with the
    // pix_X/pix_Y value they describe.
    always_comb begin
        div_next   = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        x_last     = (pix_X == X_LAST);
        y_last     = (pix_Y == Y_LAST);
        x_next     = x_last ? '0 : pix_X + XW'(1);
        y_next     = pix_Y;
        if (x_last) begin
            y_next = y_last ? '0 : pix_Y + YW'(1);
        end
        h_act_next = (int'(x_next) >= HS_START) && (int'(x_next) < HS_END);
        v_act_next = (int'(y_next) >= VS_START) && (int'(y_next) < VS_END);
        vid_next   = (int'(x_next) < H_DISPLAY) && (int'(y_next) < V_DISPLAY);
    end

    always_ff @(posedge CLK_TB) begin
        if (!RESET_TB) begin
            div_cnt     <= '0;
            p_tick      <= 1'b0;
            pix_X       <= '0;
            pix_Y       <= '0;
            h_sync      <= ~SYNC_ACT;
            v_sync      <= ~SYNC_ACT;
            videon      <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            blink       <= 1'b0;
        end else begin
            div_cnt     <= div_next;
            // p_tick is registered from the next divider value, so it mirrors
            // (div_cnt == CLK_DIV-1) while staying low during reset.
            p_tick      <= (div_next == DIV_LAST);
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            if (p_tick) begin
                pix_X       <= x_next;
                pix_Y       <= y_next;
                h_sync      <= h_act_next ? SYNC_ACT : ~SYNC_ACT;
                v_sync      <= v_act_next ? SYNC_ACT : ~SYNC_ACT;
                videon      <= vid_next;
                line_end    <= x_last;
                frame_start <= x_last && y_last;
                // The frame counter steps on the same edge that raises
                // frame_start, so blink changes together with that pulse.
                if (x_last && y_last) begin
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt <= '0;
                        blink     <= ~blink;
                    end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
